decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Pipelined ID stage directly downstream of instruction fetch. Latches the
//  fetched word and PC+1 into an IF/ID register, then decodes the MIPS subset.
//  Drives the branch/jump controls back to fetch and registers operands and
//  controls into an ID/EX register for execute. Detects load-use hazards,
//  stalls fetch, and inserts bubbles.
// PARAMETERS
//  PC_W    30  word-address width of PC / PC+1 (matches fetch)
//  RA_W    5   register-specifier width
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous, active-high
//  if_instr     in   32  instruction word at fetch address
//  if_pc1       in   30  PC+1 from fetch adder
//  if_valid     in   1   if_instr/if_pc1 hold a real instruction
//  flush        in   1   redirect taken; squash IF/ID contents
//  stall_if     out  1   hold PC this cycle (load-use)
//  branch       out  1   BNE in ID (to fetch, combinational)
//  jal          out  1   JAL in ID (to fetch)
//  jump         out  2   00 seq, 01 JR (Da), 10 J/JAL target (to fetch)
//  imm16        out  16  ID immediate (to fetch)
//  target       out  26  ID jump target (to fetch)
//  rs, rt       out  5   ID read specifiers (register-file read ports)
//  ex_valid     out  1   ID/EX holds a real instruction
//  ex_rs/rt/rd  out  5   registered specifiers; ex_rd = write reg (rt/rd/31)
//  ex_imm       out  32  sign-extended (ADDI/LW/SW) or zero-extended (XORI)
//  ex_pc1       out  30  registered PC+1 (JAL link value)
//  ex_alu_op    out  3   0 ADD,1 SUB,2 XOR,3 SLT,4 PASS_PC1
//  ex_alu_src   out  1   1 = imm as operand B
//  ex_reg_we / ex_mem_we / ex_mem_rd  out 1 each  write-back / store / load
//  illegal      out  1   1-cycle pulse: unknown opcode/funct decoded
// BEHAVIOUR
//  - Reset: IF/ID and ID/EX valid=0; all ex_* = 0; stall_if=0; illegal=0.
//  - IF/ID on edge: flush -> valid=0; else stall_if -> hold; else load
//    {if_instr, if_pc1, if_valid}.
//  - Decode is combinational from IF/ID. Fetch-facing outputs (branch, jal,
//    jump, imm16, target) are forced to 0 when IF/ID invalid or stall_if=1.
//  - ID/EX on edge: flush or stall_if or illegal -> bubble (ex_valid=0 and
//    all ex_* controls 0); else capture decode. Latency: word presented at
//    edge N is visible on ex_* after edge N+1.
//  - Opcodes: R(00: funct 20 ADD, 22 SUB, 2A SLT, 08 JR), 23 LW, 2B SW,
//    02 J, 03 JAL, 05 BNE, 08 ADDI, 0E XORI.
//  - ex_rd: R-type -> rd; ADDI/XORI/LW -> rt; JAL -> 31. ex_reg_we=0 when
//    ex_rd==0. SW, BNE, J, and JR write nothing.
//  - Load-use: stall_if = IFID.valid & IDEX.valid & ex_mem_rd & ex_rt!=0 &
//    (ex_rt==rs_used | ex_rt==rt_used). rt_used applies only to R-type, SW,
//    BNE; rs_used to all except J/JAL. Lasts exactly 1 cycle, because the
//    bubble clears the IDEX load.
//  - flush and stall_if together: flush wins; IF/ID squashed, stall drops.
//  - illegal is asserted only for a valid IF/ID that is not stalled.
// STRUCTURE
//  - Shared package mips_defs: opcode/funct localparams, ALU_OP codes, JUMP
//    encodings (00/01/10), and REG_RA = 31.
//  - One sub-module, instr_decoder (purely combinational word -> controls).
//    The pipeline registers and hazard logic stay in decode_stage.
// TESTING
//  1 reset=1 for 2 cycles with if_valid=1 -> ex_valid=0, stall_if=0,
//    all ex_*=0.
//  2 ADDI $t0,$zero,5 (0x20080005), pc1=1 -> two edges later ex_rd=8,
//    ex_imm=5, ex_alu_src=1, ex_reg_we=1.
//  3 LW $t1,0($t0) then ADD $t2,$t1,$t1 -> stall_if=1 for one cycle,
//    one bubble, then ADD enters EX with ex_rd=10.
//  4 LW $zero,0($t0) then ADD using $zero -> no stall.
//  5 BNE (0x15090003) in ID -> branch=1, imm16=3. flush on the next edge
//    -> following word squashed, ex_valid=0.
//  6 JAL 0x0000010 with pc1=7 -> jal=1, jump=10, target=0x10. In EX:
//    ex_rd=31, ex_pc1=7, ex_alu_op=PASS_PC1.
//    Opcode 0x3F -> illegal pulses once, bubble.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS-subset definitions for the decode pipeline stage.
// Opcode/funct values, ALU and jump encodings, control bundle type.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [2:0] {
        ALU_ADD      = 3'd0,
        ALU_SUB      = 3'd1,
        ALU_XOR      = 3'd2,
        ALU_SLT      = 3'd3,
        ALU_PASS_PC1 = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        JUMP_SEQ = 2'b00,
        JUMP_REG = 2'b01,
        JUMP_TGT = 2'b10
    } jump_e;

    typedef struct packed {
        logic    branch;
        logic    jal;
        jump_e   jump;
        alu_op_e alu_op;
        logic    alu_src;
        logic    reg_we;
        logic    mem_we;
        logic    mem_rd;
        logic    rs_used;
        logic    rt_used;
        logic    illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational decoder: instruction word to field and control bundle.
// reg_we here means "this instruction kind writes"; $zero masking is downstream.
module instr_decoder
    import mips_defs::*;
#(
    parameter int RA_W = 5
) (
    input  logic [31:0]     instr,
    output logic [RA_W-1:0] rs,
    output logic [RA_W-1:0] rt,
    output logic [RA_W-1:0] wr_reg,
    output logic [15:0]     imm16,
    output logic [25:0]     target,
    output logic [31:0]     imm,
    output ctrl_t           ctrl
);

    logic [5:0] op;
    logic [5:0] fn;

    assign op     = instr[31:26];
    assign fn     = instr[5:0];
    assign rs     = RA_W'(instr[25:21]);
    assign rt     = RA_W'(instr[20:16]);
    assign imm16  = instr[15:0];
    assign target = instr[25:0];

    always_comb begin
        ctrl    = '0;
        imm     = '0;
        wr_reg  = '0;
        ctrl.rs_used = !(op == OP_J || op == OP_JAL);
        ctrl.rt_used = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BNE);
        case (op)
            OP_RTYPE: begin
                wr_reg = RA_W'(instr[15:11]);
                case (fn)
                    FN_ADD: begin
                        ctrl.reg_we = 1'b1;
                        ctrl.alu_op = ALU_ADD;
                    end
                    FN_SUB: begin
                        ctrl.reg_we = 1'b1;
                        ctrl.alu_op = ALU_SUB;
                    end
                    FN_SLT: begin
                        ctrl.reg_we = 1'b1;
                        ctrl.alu_op = ALU_SLT;
                    end
                    FN_JR:   ctrl.jump    = JUMP_REG;
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                wr_reg       = RA_W'(instr[20:16]);
                imm          = {{16{instr[15]}}, instr[15:0]};
                ctrl.reg_we  = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.mem_rd  = 1'b1;
            end
            OP_SW: begin
                imm          = {{16{instr[15]}}, instr[15:0]};
                ctrl.alu_src = 1'b1;
                ctrl.mem_we  = 1'b1;
            end
            OP_J: ctrl.jump = JUMP_TGT;
            OP_JAL: begin
                wr_reg      = RA_W'(REG_RA);
                ctrl.jump   = JUMP_TGT;
                ctrl.jal    = 1'b1;
                ctrl.reg_we = 1'b1;
                ctrl.alu_op = ALU_PASS_PC1;
            end
            OP_BNE: ctrl.branch = 1'b1;
            OP_ADDI: begin
                wr_reg       = RA_W'(instr[20:16]);
                imm          = {{16{instr[15]}}, instr[15:0]};
                ctrl.reg_we  = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALU_ADD;
            end
            OP_XORI: begin
                wr_reg       = RA_W'(instr[20:16]);
                imm          = {16'h0000, instr[15:0]};
                ctrl.reg_we  = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALU_XOR;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: IF/ID register, decode, load-use interlock and ID/EX register.
// Fetch-facing controls are combinational from IF/ID.
module decode_stage
    import mips_defs::*;
#(
    parameter int PC_W = 30,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     if_instr,
    input  logic [PC_W-1:0] if_pc1,
    input  logic            if_valid,
    input  logic            flush,
    output logic            stall_if,
    output logic            branch,
    output logic            jal,
    output logic [1:0]      jump,
    output logic [15:0]     imm16,
    output logic [25:0]     target,
    output logic [RA_W-1:0] rs,
    output logic [RA_W-1:0] rt,
    output logic            ex_valid,
    output logic [RA_W-1:0] ex_rs,
    output logic [RA_W-1:0] ex_rt,
    output logic [RA_W-1:0] ex_rd,
    output logic [31:0]     ex_imm,
    output logic [PC_W-1:0] ex_pc1,
    output logic [2:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_reg_we,
    output logic            ex_mem_we,
    output logic            ex_mem_rd,
    output logic            illegal
);

    logic [31:0]     ifid_instr;
    logic [PC_W-1:0] ifid_pc1;
    logic            ifid_valid;

    logic [RA_W-1:0] dec_rs;
    logic [RA_W-1:0] dec_rt;
    logic [RA_W-1:0] dec_wr;
    logic [15:0]     dec_imm16;
    logic [25:0]     dec_target;
    logic [31:0]     dec_imm;
    ctrl_t           dec_ctrl;

    logic hazard;
    logic fe_ok;
    logic bubble;

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_instr <= '0;
            ifid_pc1   <= '0;
            ifid_valid <= 1'b0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
        end else if (!stall_if) begin
            ifid_instr <= if_instr;
            ifid_pc1   <= if_pc1;
            ifid_valid <= if_valid;
        end
    end

    instr_decoder #(
        .RA_W(RA_W)
    ) u_dec (
        .instr  (ifid_instr),
        .rs     (dec_rs),
        .rt     (dec_rt),
        .wr_reg (dec_wr),
        .imm16  (dec_imm16),
        .target (dec_target),
        .imm    (dec_imm),
        .ctrl   (dec_ctrl)
    );

    assign rs = dec_rs;
    assign rt = dec_rt;

    // The bubble it forces clears ex_mem_rd, so the interlock self-releases.
    assign hazard = ifid_valid && ex_valid && ex_mem_rd
                 && (ex_rt != '0)
                 && ((dec_ctrl.rs_used && ex_rt == dec_rs)
                  || (dec_ctrl.rt_used && ex_rt == dec_rt));

    assign stall_if = hazard && !flush;
    assign illegal  = ifid_valid && !stall_if && dec_ctrl.illegal;
    assign fe_ok    = ifid_valid && !stall_if;

    assign branch = fe_ok && dec_ctrl.branch;
    assign jal    = fe_ok && dec_ctrl.jal;
    assign jump   = fe_ok ? dec_ctrl.jump : JUMP_SEQ;
    assign imm16  = fe_ok ? dec_imm16 : '0;
    assign target = fe_ok ? dec_target : '0;

    assign bubble = flush || stall_if || illegal || !ifid_valid;

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            ex_valid   <= 1'b0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_imm     <= '0;
            ex_pc1     <= '0;
            ex_alu_op  <= '0;
            ex_alu_src <= 1'b0;
            ex_reg_we  <= 1'b0;
            ex_mem_we  <= 1'b0;
            ex_mem_rd  <= 1'b0;
        end else begin
            ex_valid   <= 1'b1;
            ex_rs      <= dec_rs;
            ex_rt      <= dec_rt;
            ex_rd      <= dec_wr;
            ex_imm     <= dec_imm;
            ex_pc1     <= ifid_pc1;
            ex_alu_op  <= dec_ctrl.alu_op;
            ex_alu_src <= dec_ctrl.alu_src;
            ex_reg_we  <= dec_ctrl.reg_we && (dec_wr != '0);
            ex_mem_we  <= dec_ctrl.mem_we;
            ex_mem_rd  <= dec_ctrl.mem_rd;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus random instruction
// streams compared every cycle against a table-driven reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_instr;
    logic [29:0] if_pc1;
    logic        if_valid;
    logic        flush;
    logic        stall_if;
    logic        branch;
    logic        jal;
    logic [1:0]  jump;
    logic [15:0] imm16;
    logic [25:0] target;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        ex_valid;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [31:0] ex_imm;
    logic [29:0] ex_pc1;
    logic [2:0]  ex_alu_op;
    logic        ex_alu_src;
    logic        ex_reg_we;
    logic        ex_mem_we;
    logic        ex_mem_rd;
    logic        illegal;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .reset      (reset),
        .if_instr   (if_instr),
        .if_pc1     (if_pc1),
        .if_valid   (if_valid),
        .flush      (flush),
        .stall_if   (stall_if),
        .branch     (branch),
        .jal        (jal),
        .jump       (jump),
        .imm16      (imm16),
        .target     (target),
        .rs         (rs),
        .rt         (rt),
        .ex_valid   (ex_valid),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_rd      (ex_rd),
        .ex_imm     (ex_imm),
        .ex_pc1     (ex_pc1),
        .ex_alu_op  (ex_alu_op),
        .ex_alu_src (ex_alu_src),
        .ex_reg_we  (ex_reg_we),
        .ex_mem_we  (ex_mem_we),
        .ex_mem_rd  (ex_mem_rd),
        .illegal    (illegal)
    );

    typedef struct packed {
        bit        v;
        bit [4:0]  rs;
        bit [4:0]  rt;
        bit [4:0]  rd;
        bit [31:0] imm;
        bit [29:0] pc1;
        bit [2:0]  op;
        bit        src;
        bit        we;
        bit        mwe;
        bit        mrd;
    } ex_t;

    typedef struct packed {
        bit       ill;
        bit       br;
        bit       jl;
        bit [1:0] jmp;
        bit       rsu;
        bit       rtu;
        ex_t      ex;
    } dec_t;

    int checks   = 0;
    int failures = 0;

    bit        m_known = 1'b0;
    bit        m_if_v;
    bit [31:0] m_if_w;
    bit [29:0] m_if_p;
    ex_t       m_ex;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: what each MIPS instruction means for EX and fetch.
    function automatic dec_t ref_dec(bit [31:0] w, bit [29:0] p);
        dec_t r;
        bit [5:0] op;
        bit [15:0] i;
        op = w[31:26];
        i  = w[15:0];
        r = '0;
        r.ex.v   = 1'b1;
        r.ex.rs  = w[25:21];
        r.ex.rt  = w[20:16];
        r.ex.pc1 = p;
        r.rsu = !(op == 6'h02 || op == 6'h03);
        r.rtu = (op == 6'h00 || op == 6'h2B || op == 6'h05);
        case (op)
            6'h00: begin
                r.ex.rd = w[15:11];
                case (w[5:0])
                    6'h20: begin r.ex.we = 1; r.ex.op = 0; end
                    6'h22: begin r.ex.we = 1; r.ex.op = 1; end
                    6'h2A: begin r.ex.we = 1; r.ex.op = 3; end
                    6'h08: r.jmp = 2'b01;
                    default: r.ill = 1;
                endcase
            end
            6'h23: begin
                r.ex.rd = w[20:16]; r.ex.we = 1; r.ex.src = 1; r.ex.mrd = 1;
                r.ex.imm = 32'($signed(i));
            end
            6'h2B: begin
                r.ex.src = 1; r.ex.mwe = 1;
                r.ex.imm = 32'($signed(i));
            end
            6'h02: r.jmp = 2'b10;
            6'h03: begin
                r.jmp = 2'b10; r.jl = 1; r.ex.rd = 31; r.ex.we = 1; r.ex.op = 4;
            end
            6'h05: r.br = 1;
            6'h08: begin
                r.ex.rd = w[20:16]; r.ex.we = 1; r.ex.src = 1;
                r.ex.imm = 32'($signed(i));
            end
            6'h0E: begin
                r.ex.rd = w[20:16]; r.ex.we = 1; r.ex.src = 1; r.ex.op = 2;
                r.ex.imm = {16'h0, i};
            end
            default: r.ill = 1;
        endcase
        if (r.ex.rd == 0) r.ex.we = 0;
        return r;
    endfunction

    task automatic step(input bit [31:0] w, input bit [29:0] p,
                        input bit v, input bit f, input bit r);
        dec_t d;
        bit haz, stl, ill, ok;
        @(negedge clk);
        if_instr = w;
        if_pc1   = p;
        if_valid = v;
        flush    = f;
        reset    = r;
        #1;
        if (m_known) begin
            d   = ref_dec(m_if_w, m_if_p);
            haz = m_if_v && m_ex.v && m_ex.mrd && m_ex.rt != 0
                && ((d.rsu && m_ex.rt == m_if_w[25:21])
                 || (d.rtu && m_ex.rt == m_if_w[20:16]));
            stl = haz && !f;
            ill = m_if_v && !stl && d.ill;
            ok  = m_if_v && !stl;
            check("stall_if", stall_if, stl);
            check("illegal", illegal, ill);
            check("branch", branch, ok && d.br);
            check("jal", jal, ok && d.jl);
            check("jump", jump, ok ? d.jmp : 2'b00);
            check("imm16", imm16, ok ? m_if_w[15:0] : 16'h0);
            check("target", target, ok ? m_if_w[25:0] : 26'h0);
            check("rs", rs, m_if_w[25:21]);
            check("rt", rt, m_if_w[20:16]);
            check("ex_valid", ex_valid, m_ex.v);
            check("ex_rs", ex_rs, m_ex.rs);
            check("ex_rt", ex_rt, m_ex.rt);
            check("ex_rd", ex_rd, m_ex.rd);
            check("ex_imm", ex_imm, m_ex.imm);
            check("ex_pc1", ex_pc1, m_ex.pc1);
            check("ex_alu_op", ex_alu_op, m_ex.op);
            check("ex_alu_src", ex_alu_src, m_ex.src);
            check("ex_reg_we", ex_reg_we, m_ex.we);
            check("ex_mem_we", ex_mem_we, m_ex.mwe);
            check("ex_mem_rd", ex_mem_rd, m_ex.mrd);
            if (r) m_ex = '0;
            else if (f || stl || ill || !m_if_v) m_ex = '0;
            else m_ex = d.ex;
            if (r) begin
                m_if_v = 0; m_if_w = 0; m_if_p = 0;
            end else if (f) begin
                m_if_v = 0;
            end else if (!stl) begin
                m_if_v = v; m_if_w = w; m_if_p = p;
            end
        end else if (r) begin
            m_known = 1;
            m_ex = '0;
            m_if_v = 0; m_if_w = 0; m_if_p = 0;
        end
    endtask

    function automatic bit [31:0] rnd_instr();
        bit [5:0] ops [9];
        bit [5:0] fns [4];
        bit [5:0] op, fn;
        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h02, 6'h03, 6'h05, 6'h08, 6'h0E};
        fns = '{6'h20, 6'h22, 6'h2A, 6'h08};
        op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
        fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 3)];
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom), fn};
    endfunction

    initial begin
        reset = 1; if_instr = 0; if_pc1 = 0; if_valid = 0; flush = 0;

        step(32'h20080005, 30'd1, 1, 0, 1);
        step(32'h20080005, 30'd1, 1, 0, 1);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_stall", stall_if, 0);
        check("rst_ex_imm", ex_imm, 0);
        check("rst_ex_reg_we", ex_reg_we, 0);

        step(32'h20080005, 30'd1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("addi_ex_rd", ex_rd, 8);
        check("addi_ex_imm", ex_imm, 5);
        check("addi_alu_src", ex_alu_src, 1);
        check("addi_reg_we", ex_reg_we, 1);

        step(32'h8D090000, 30'd2, 1, 0, 0);
        step(32'h01295020, 30'd3, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("lu_stall", stall_if, 1);
        step(0, 0, 0, 0, 0);
        check("lu_stall_drop", stall_if, 0);
        check("lu_bubble", ex_valid, 0);
        step(0, 0, 0, 0, 0);
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_rd", ex_rd, 10);

        step(32'h8D000000, 30'd2, 1, 0, 0);
        step(32'h00005020, 30'd3, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("lw0_no_stall", stall_if, 0);
        check("lw0_reg_we", ex_reg_we, 0);
        step(0, 0, 0, 0, 0);

        step(32'h15090003, 30'd4, 1, 0, 0);
        step(32'h20080005, 30'd5, 1, 1, 0);
        check("bne_branch", branch, 1);
        check("bne_imm16", imm16, 3);
        step(0, 0, 0, 0, 0);
        check("bne_flush_ex", ex_valid, 0);
        step(0, 0, 0, 0, 0);
        check("flush_squash", ex_valid, 0);

        step(32'h0C000010, 30'd7, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("jal_jal", jal, 1);
        check("jal_jump", jump, 2'b10);
        check("jal_target", target, 26'h10);
        step(0, 0, 0, 0, 0);
        check("jal_ex_rd", ex_rd, 31);
        check("jal_ex_pc1", ex_pc1, 7);
        check("jal_alu_op", ex_alu_op, 4);

        step(32'hFC000000, 30'd8, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("ill_pulse", illegal, 1);
        step(0, 0, 0, 0, 0);
        check("ill_drop", illegal, 0);
        check("ill_bubble", ex_valid, 0);

        step(32'h8D090000, 30'd2, 1, 0, 0);
        step(32'h01295020, 30'd3, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        check("flush_beats_stall", stall_if, 0);
        step(0, 0, 0, 0, 0);
        check("flush_stall_ex", ex_valid, 0);

        for (int n = 0; n < 600; n++) begin
            step(rnd_instr(), 30'($urandom),
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
